uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
//  16x-oversampled UART receiver, 8N1, LSB first. It is the receive counterpart of the
//  16x-clocked uart_tx and sits on the UART side of the protocol converter.
//  Synchronises the asynchronous rx pin and finds each frame from its start-bit falling edge.
//  Majority-votes 3 samples at mid-bit and presents each byte with a 1-cycle valid strobe.
//  Flags framing errors.
//
// PARAMETERS
//  BAUD_TICK_COUNT  16  clk_16x cycles per bit. Legal range 8..16 (tick_cnt is 4 bits).
//  MID_TICK         BAUD_TICK_COUNT/2  centre sample tick (derived localparam, not overridable).
//
// PORTS
//  clk_16x    in   1  oversample clock (16x baud); the only clock
//  rst        in   1  synchronous, active-high reset
//  rx         in   1  asynchronous serial input, idle high
//  rx_data    out  8  last received byte; held until the next frame completes
//  rx_valid   out  1  1-cycle strobe: rx_data holds a good byte
//  rx_busy    out  1  high while a frame is in progress (state != IDLE)
//  frame_err  out  1  1-cycle strobe: the stop bit sampled low
//
// BEHAVIOUR
//  Reset (rst=1 at a clk_16x edge, any state, mid-frame included):
//   - state=IDLE; tick_cnt=0; bit_idx=0; shift_reg=0.
//   - Both synchroniser FFs = 1.
//   - rx_data=8'h00; rx_valid=0; rx_busy=0; frame_err=0.
//   - Any partially received frame is discarded.
//  Synchroniser: rx passes through a 2-FF chain; only rx_s (2nd FF) is used downstream.
//  Counter: tick_cnt counts 0..BAUD_TICK_COUNT-1 and wraps to 0 in START/DATA/STOP.
//  Voting:
//   - rx_s is sampled at tick_cnt = MID_TICK-1, MID_TICK and MID_TICK+1.
//   - vote = majority of the 3 samples, resolved at MID_TICK+1.
//  States:
//   - IDLE: when rx_s==0, go to START with tick_cnt=0. rx_busy=0 in this state only.
//   - START: at MID_TICK+1, vote==1 means a glitch: go to IDLE, no strobe.
//     Otherwise, at tick BAUD_TICK_COUNT-1, go to DATA with bit_idx=0 and tick_cnt=0.
//   - DATA: at MID_TICK+1, shift_reg[bit_idx] <= vote.
//     At tick BAUD_TICK_COUNT-1: if bit_idx==7 go to STOP, else bit_idx++.
//   - STOP: at MID_TICK+1, rx_data <= shift_reg regardless of the vote.
//     vote==1: pulse rx_valid for 1 cycle and go to IDLE. This does not wait for the end of
//       the stop bit, which allows resync on back-to-back frames.
//     vote==0: pulse frame_err for 1 cycle (rx_valid stays 0) and go to WAIT_HIGH.
//   - WAIT_HIGH: break / stuck-low line. Stay in this state until rx_s==1, then go to IDLE.
//     No new start is detected until the line returns high. rx_busy=1.
//  Outputs: rx_valid and frame_err are registered and never both high; each is high for
//   exactly 1 cycle per frame.
//  Latency: rx_valid rises 9*BAUD_TICK_COUNT + MID_TICK + 4 (+/-1) cycles after rx falls.
//   The +/-1 covers synchroniser phase.
//  Rate tolerance: frames from a transmitter up to +/-3% off baud are received correctly.
//  Back-to-back frames: a start bit directly after the stop bit is received with no byte lost.
//  rx is ignored while rst=1.
//
// TESTING (BAUD_TICK_COUNT=16)
//  1. Drive 0xA5 as 8N1, 16 clk per bit -> rx_valid=1 for 1 cycle, rx_data=8'hA5,
//     frame_err=0, rx_busy falls with the strobe.
//  2. Loopback from uart_tx: send 0x00, 0xFF, 0x55, 0x3C back-to-back -> 4 strobes, bytes in
//     order, no frame_err.
//  3. rx low for 4 cycles, then high -> START aborts at tick 9; no rx_valid or frame_err;
//     rx_busy=0 within 12 cycles.
//  4. Frame 0x81 with the stop bit held low, line low for 200 cycles, then high ->
//     frame_err pulses once, rx_data=8'h81, rx_valid=0. A following 0x42 frame after the line
//     returns high is received correctly.
//  5. Assert rst at tick 5 of data bit 3, then send 0x7E -> all outputs are at reset values
//     during rst; afterwards rx_valid=1 with rx_data=8'h7E and no stale bits.
//  6. 1-cycle low glitch at the centre of each data bit of 0xC3 -> voting masks the glitches;
//     rx_data=8'hC3.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART: serial input plus the received-byte outputs.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  // Master drives the serial line and observes the receiver outputs.
  modport master (output rx, input rx_data, input rx_valid, input rx_busy, input frame_err);
  // Slave is the receiver itself.
  modport slave  (input rx, output rx_data, output rx_valid, output rx_busy, output frame_err);
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver with 3-sample majority vote and framing-error flag.
module uart_rx #(
  parameter int unsigned BAUD_TICK_COUNT = 16
) (
  input  logic      clk_16x,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int unsigned MID_TICK  = BAUD_TICK_COUNT / 2;
  localparam logic [3:0]  TICK_LAST = 4'(BAUD_TICK_COUNT - 1);
  localparam logic [3:0]  TICK_S0   = 4'(MID_TICK - 1);
  localparam logic [3:0]  TICK_S1   = 4'(MID_TICK);
  localparam logic [3:0]  TICK_VOTE = 4'(MID_TICK + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic [1:0] samp_q, samp_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       rx_meta, rx_s;
  logic       vote_c;

  // Two-FF synchroniser for the asynchronous rx pin; idles high.
  always_ff @(posedge clk_16x) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // Majority of the two stored samples and the current one at the vote tick.
  assign vote_c = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  // State and datapath registers.
  always_ff @(posedge clk_16x) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      samp_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      samp_q  <= samp_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, bit sampling and strobe generation.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    samp_d  = samp_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (state_q != IDLE && state_q != WAIT_HIGH) begin
      tick_d = (tick_q == TICK_LAST) ? 4'd0 : tick_q + 4'd1;
      if (tick_q == TICK_S0) samp_d[0] = rx_s;
      if (tick_q == TICK_S1) samp_d[1] = rx_s;
    end

    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (tick_q == TICK_VOTE && vote_c) begin
          state_d = IDLE;
          tick_d  = '0;
        end else if (tick_q == TICK_LAST) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick_q == TICK_VOTE) shift_d[bit_q] = vote_c;
        if (tick_q == TICK_LAST) begin
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        // Resolve at mid stop bit so a back-to-back start edge is not missed.
        if (tick_q == TICK_VOTE) begin
          data_d = shift_q;
          tick_d = '0;
          if (vote_c) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_busy   = busy_q;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a scoreboard of expected bytes / framing errors.
module tb_uart_rx;

  localparam int unsigned BIT_T = 16;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk_16x = 1'b0;
  logic rst     = 1'b1;
  uart_rx_if bus ();

  uart_rx #(.BAUD_TICK_COUNT(BIT_T)) dut (
    .clk_16x (clk_16x),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 clk_16x = ~clk_16x;

  exp_t   sb[$];
  int     errors    = 0;
  int     checks    = 0;
  int     valid_cnt = 0;
  int     err_cnt   = 0;
  logic   prev_valid = 1'b0;
  logic   prev_err   = 1'b0;
  time    fall_t     = 0;
  time    valid_t    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every strobe.
  always @(negedge clk_16x) begin
    if (!rst) begin
      if (bus.rx_valid || bus.frame_err) begin
        chk("valid_err_exclusive", 32'(bus.rx_valid & bus.frame_err), 0);
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("strobe_kind", 32'(bus.frame_err), 32'(e.err));
          chk("rx_data", 32'(bus.rx_data), 32'(e.data));
        end
      end
      if (bus.rx_valid) begin
        chk("valid_one_cycle", 32'(prev_valid), 0);
        chk("busy_falls_with_valid", 32'(bus.rx_busy), 0);
        valid_cnt++;
        valid_t = $time;
      end
      if (bus.frame_err) begin
        chk("err_one_cycle", 32'(prev_err), 0);
        chk("busy_in_wait_high", 32'(bus.rx_busy), 1);
        err_cnt++;
      end
    end
    prev_valid = bus.rx_valid;
    prev_err   = bus.frame_err;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_16x);
  endtask

  // One 8N1 frame; optionally a 1-cycle inverted glitch at the centre of each data bit.
  task automatic send(input logic [7:0] d, input logic stop, input logic glitch);
    sb.push_back({~stop, d});
    bus.rx = 1'b0;
    fall_t = $time;
    wait_cyc(BIT_T);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_cyc(BIT_T / 2);
      if (glitch) bus.rx = ~d[i];
      wait_cyc(1);
      bus.rx = d[i];
      wait_cyc(BIT_T / 2 - 1);
    end
    bus.rx = stop;
    wait_cyc(BIT_T);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_data"},   32'(bus.rx_data), 0);
    chk({tag, "_rx_valid"},  32'(bus.rx_valid), 0);
    chk({tag, "_rx_busy"},   32'(bus.rx_busy), 0);
    chk({tag, "_frame_err"}, 32'(bus.frame_err), 0);
  endtask

  initial begin
    int v0, e0, budget;
    logic [7:0] junk;
    bus.rx = 1'b1;
    rst    = 1'b1;
    wait_cyc(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_cyc(20);

    // 1: single 0xA5 frame, latency and busy while in frame
    send(8'hA5, 1'b1, 1'b0);
    chk("latency_ok", 32'((valid_t - fall_t) / 10 >= 155 && (valid_t - fall_t) / 10 <= 158), 1);
    wait_cyc(20);

    // 2: back-to-back frames
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    wait_cyc(20);
    chk("b2b_valid_count", 32'(valid_cnt), 5);

    // 3: short start glitch aborts
    v0 = valid_cnt; e0 = err_cnt;
    bus.rx = 1'b0;
    wait_cyc(4);
    bus.rx = 1'b1;
    wait_cyc(2);
    chk("glitch_busy_mid", 32'(bus.rx_busy), 1);
    wait_cyc(10);
    chk("glitch_busy_cleared", 32'(bus.rx_busy), 0);
    wait_cyc(20);
    chk("glitch_no_strobe", 32'((valid_cnt - v0) + (err_cnt - e0)), 0);

    // 4: stop bit low, long break, then recovery frame
    v0 = valid_cnt; e0 = err_cnt;
    send(8'h81, 1'b0, 1'b0);
    wait_cyc(200);
    chk("break_busy", 32'(bus.rx_busy), 1);
    bus.rx = 1'b1;
    wait_cyc(20);
    chk("break_err_once", 32'(err_cnt - e0), 1);
    chk("break_no_valid", 32'(valid_cnt - v0), 0);
    chk("break_data_held", 32'(bus.rx_data), 32'h81);
    send(8'h42, 1'b1, 1'b0);
    wait_cyc(20);

    // 5: reset in the middle of data bit 3, then a clean frame
    junk = 8'h99;
    bus.rx = 1'b0;
    wait_cyc(BIT_T);
    for (int i = 0; i < 3; i++) begin
      bus.rx = junk[i];
      wait_cyc(BIT_T);
    end
    bus.rx = junk[3];
    wait_cyc(5);
    rst = 1'b1;
    bus.rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_cyc(1);
      check_reset_outputs("midreset");
    end
    bus.rx = 1'b1;
    rst = 1'b0;
    wait_cyc(10);
    send(8'h7E, 1'b1, 1'b0);
    wait_cyc(20);

    // 6: centre-of-bit glitches masked by the vote
    send(8'hC3, 1'b1, 1'b1);

    budget = 500;
    while (sb.size() != 0 && budget > 0) begin
      wait_cyc(1);
      budget--;
    end
    chk("sb_drained", 32'(sb.size()), 0);
    wait_cyc(20);
    chk("total_valid", 32'(valid_cnt), 8);
    chk("total_frame_err", 32'(err_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
